// File: rtl/uart_rx_buffered.sv
// UART receiver with a first-word-fall-through receive buffer and sticky error flags.
// Latency: a good word shows on valid_out two edges after its last stop-bit sample.
// Backpressure: ready_in pops the head; when full a new word is dropped (overflow_out), and cts_out asks the sender to pause.
module uart_rx_buffered #(
    parameter int BAUD_COUNT = 645,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rx_in,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [$clog2(FIFO_DEPTH):0] count_out,
    output logic                        cts_out,
    output logic                        frame_err_out,
    output logic                        parity_err_out,
    output logic                        overflow_out,
    input  logic                        err_clr_in
);

    localparam int CW = $clog2(BAUD_COUNT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] HALF_M1   = CW'(BAUD_COUNT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(BAUD_COUNT - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);
    localparam logic [NW-1:0] CTS_LVL   = NW'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    // Synchronizer and edge-detect state
    logic       rx_meta_q;
    logic       rx_sync_q;
    logic       rx_prev_q;
    logic [1:0] warm_q;

    // Receiver FSM state
    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [3:0]            bit_q;
    logic                  stop_idx_q;
    logic                  stop_bad_q;
    logic                  par_bad_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  done_q;
    logic                  frame_err_q;
    logic                  parity_err_q;

    // Push stage and FIFO
    logic                  push_q;
    logic [DATA_WIDTH-1:0] push_dat_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    logic [NW-1:0]         count_q;
    logic [NW-1:0]         count_d;
    logic                  cts_q;
    logic                  overflow_q;

    logic start_edge;
    logic stop_fail;
    logic par_sum;
    logic par_fail;
    logic full;
    logic do_pop;
    logic do_push;

    // A falling edge only counts once rx_prev_q holds a genuinely observed line value.
    assign start_edge = rx_prev_q & ~rx_sync_q;
    assign stop_fail  = stop_bad_q | ~rx_sync_q;
    assign par_sum    = (^shreg_q) ^ rx_sync_q;
    assign par_fail   = (PARITY == 1) ? ~par_sum : par_sum;

    assign full    = (count_q == DEPTH_N);
    assign do_pop  = valid_out & ready_in;
    assign do_push = push_q & (~full | do_pop);

    // Two-flop synchronizer; rx_prev_q stays low until the synchronizer holds real line data,
    // so a line held low through reset never looks like a start edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b0;
            warm_q    <= 2'b00;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
            warm_q    <= {warm_q[0], 1'b1};
            rx_prev_q <= warm_q[1] ? rx_sync_q : 1'b0;
        end
    end

    // Frame receiver FSM: bit timing, data shift, parity/stop checking, error flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            stop_idx_q   <= 1'b0;
            stop_bad_q   <= 1'b0;
            par_bad_q    <= 1'b0;
            shreg_q      <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (err_clr_in) begin
                frame_err_q  <= 1'b0;
                parity_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        cnt_q   <= HALF_M1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == '0) begin
                        if (!rx_sync_q) begin
                            state_q   <= ST_DATA;
                            cnt_q     <= FULL_M1;
                            bit_q     <= '0;
                            par_bad_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == '0) begin
                        shreg_q <= {rx_sync_q, shreg_q[DATA_WIDTH-1:1]};
                        cnt_q   <= FULL_M1;
                        if (bit_q == LAST_BIT) begin
                            state_q    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            stop_idx_q <= 1'b0;
                            stop_bad_q <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == '0) begin
                        par_bad_q <= par_fail;
                        state_q   <= ST_STOP;
                        cnt_q     <= FULL_M1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == '0) begin
                        if (stop_idx_q == LAST_STOP) begin
                            if (stop_fail) begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_BREAK;
                                cnt_q       <= FULL_M1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end
                            done_q <= ~stop_fail & ~par_bad_q;
                        end else begin
                            stop_idx_q <= 1'b1;
                            stop_bad_q <= stop_fail;
                            cnt_q      <= FULL_M1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_BREAK: begin
                    // Any low sample restarts the full-bit high requirement.
                    if (!rx_sync_q) begin
                        cnt_q <= FULL_M1;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Next occupancy from this edge's push/pop pair.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + NW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - NW'(1);
        end
    end

    // Push stage, FIFO pointers/occupancy, flow control and overflow flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            push_q     <= 1'b0;
            push_dat_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            cts_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            push_q     <= done_q;
            push_dat_q <= shreg_q;
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            cts_q   <= (count_d >= CTS_LVL);
            if (err_clr_in) begin
                overflow_q <= 1'b0;
            end
            if (push_q && full && !do_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Buffer storage; written only on an accepted push.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_dat_q;
        end
    end

    assign valid_out      = (count_q != '0);
    assign data_out       = valid_out ? mem_q[rptr_q] : '0;
    assign count_out      = count_q;
    assign cts_out        = cts_q;
    assign frame_err_out  = frame_err_q;
    assign parity_err_out = parity_err_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: an 8N1 instance (a) and an 8E2 instance (b) at 16 clocks per bit.
// Expected words are queued when a frame is sent; a monitor checks every pop against the queue.
// Directed checks cover timing, errors, break, overflow, flow control and reset.
module tb_uart_rx_buffered;

    localparam int BAUD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, ready_a, clr_a, valid_a, cts_a, ferr_a, perr_a, ovf_a;
    logic [7:0] data_a;
    logic [3:0] count_a;
    logic       rx_b, ready_b, clr_b, valid_b, cts_b, ferr_b, perr_b, ovf_b;
    logic [7:0] data_b;
    logic [3:0] count_b;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    bit         rand_rdy = 1'b0;

    always #5 clk = ~clk;

    uart_rx_buffered #(.BAUD_COUNT(BAUD), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_a (
        .clk_in(clk), .rst_in(rst), .rx_in(rx_a), .data_out(data_a), .valid_out(valid_a),
        .ready_in(ready_a), .count_out(count_a), .cts_out(cts_a), .frame_err_out(ferr_a),
        .parity_err_out(perr_a), .overflow_out(ovf_a), .err_clr_in(clr_a));

    uart_rx_buffered #(.BAUD_COUNT(BAUD), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(8)) dut_b (
        .clk_in(clk), .rst_in(rst), .rx_in(rx_b), .data_out(data_b), .valid_out(valid_b),
        .ready_in(ready_b), .count_out(count_b), .cts_out(cts_b), .frame_err_out(ferr_b),
        .parity_err_out(perr_b), .overflow_out(ovf_b), .err_clr_in(clr_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a pop happens on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL pop_a: got unexpected word 0x%0h, expected no word", data_a);
            end else begin
                e = exp_a.pop_front();
                check("pop_a", data_a, e);
            end
        end
        if (valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL pop_b: got unexpected word 0x%0h, expected no word", data_b);
            end else begin
                e = exp_b.pop_front();
                check("pop_b", data_b, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            ready_a = 1'($urandom_range(0, 1));
            ready_b = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Reference framing: instance a is 8N1, instance b is 8 data + even parity + 2 stops.
    // A word is expected out only if parity is right and every stop bit is high.
    task automatic send(input bit sel, input logic [7:0] d, input bit bad_par, input bit bad_stop,
                        input bit expect_push);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (sel) bits.push_back((^d) ^ bad_par);
        for (int s = 0; s < (sel ? 2 : 1); s++) bits.push_back(~bad_stop);
        if (expect_push && !bad_par && !bad_stop) begin
            if (sel) exp_b.push_back(d);
            else exp_a.push_back(d);
        end
        foreach (bits[k]) begin
            if (sel) rx_b = bits[k];
            else rx_a = bits[k];
            idle(BAUD);
        end
    endtask

    initial begin
        int n;
        logic [7:0] w;
        bit any_bad;
        rst = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b0; ready_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        #2 rst = 1'b1;
        idle(3);
        check("rst_valid", valid_a, 0);
        check("rst_count", count_a, 0);
        check("rst_cts", cts_a, 0);
        check("rst_flags", {ferr_a, perr_a, ovf_a}, 0);
        check("rst_data", data_a, 0);
        rst = 1'b0;
        idle(5);

        // 0xA5 8N1: stop sample on edge 155 after the start bit is driven, valid on edge 157.
        fork
            send(0, 8'hA5, 0, 0, 1);
            begin
                repeat (156) @(posedge clk);
                #1 check("lat_before", valid_a, 0);
                @(posedge clk);
                #1 check("lat_valid", valid_a, 1);
                check("lat_data", data_a, 8'hA5);
                check("lat_count", count_a, 1);
            end
        join
        check("a5_flags", {ferr_a, perr_a, ovf_a}, 0);
        ready_a = 1'b1;
        idle(5);
        check("a5_drained", exp_a.size(), 0);

        // Short low glitch in IDLE is rejected at mid start bit.
        rx_a = 1'b0; idle(3); rx_a = 1'b1; idle(40);
        check("glitch_count", count_a, 0);
        check("glitch_flags", {ferr_a, perr_a, ovf_a}, 0);
        send(0, 8'h5A, 0, 0, 1);
        idle(5);
        check("after_glitch", exp_a.size(), 0);

        // Bad stop bit with err_clr on the same edge as the set: the flag must still be set.
        fork
            send(0, 8'h3C, 0, 1, 1);
            begin
                repeat (154) @(posedge clk);
                #1 clr_a = 1'b1;
                @(posedge clk);
                #1 clr_a = 1'b0;
            end
        join
        idle(40);
        check("break_ferr", ferr_a, 1);
        check("break_count", count_a, 0);
        rx_a = 1'b1;
        idle(16);
        send(0, 8'h11, 0, 0, 1);
        idle(5);
        check("after_break", exp_a.size(), 0);
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        check("ferr_cleared", ferr_a, 0);

        // Even parity: 0x07 needs parity bit 1.
        send(1, 8'h07, 1, 0, 1);
        check("par_err", perr_b, 1);
        check("par_count", count_b, 0);
        send(1, 8'h07, 0, 0, 1);
        check("par_good_count", count_b, 1);
        check("par_sticky", perr_b, 1);
        ready_b = 1'b1;
        idle(5);
        check("par_drained", exp_b.size(), 0);

        // Nine back-to-back words with no consumer: eight stored, ninth overflows.
        ready_a = 1'b0;
        for (int k = 0; k < 9; k++) begin
            send(0, 8'(k), 0, 0, k < 8);
            n = (k + 1 < 8) ? k + 1 : 8;
            check("fill_count", count_a, n);
            check("fill_cts", cts_a, n >= 6);
            if (k == 7) check("fill_no_ovf", ovf_a, 0);
        end
        check("ovf_set", ovf_a, 1);
        ready_a = 1'b1;
        idle(20);
        check("fill_drained", exp_a.size(), 0);
        check("drain_count", count_a, 0);
        check("drain_cts", cts_a, 0);
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        check("ovf_cleared", ovf_a, 0);

        // Full FIFO, consumer pulses ready on the push edge: both happen, no overflow.
        ready_a = 1'b0;
        for (int k = 0; k < 8; k++) send(0, 8'(8'h40 + k), 0, 0, 1);
        check("full_count", count_a, 8);
        fork
            send(0, 8'hC3, 0, 0, 1);
            begin
                repeat (156) @(posedge clk);
                #1 ready_a = 1'b1;
                @(posedge clk);
                #1 ready_a = 1'b0;
            end
        join
        check("pushpop_count", count_a, 8);
        check("pushpop_ovf", ovf_a, 0);

        // Reset mid-frame flushes the FIFO at once.
        fork
            send(0, 8'h99, 0, 0, 0);
            begin
                repeat (60) @(posedge clk);
                #1 rst = 1'b1;
                #1;
                check("midrst_count", count_a, 0);
                check("midrst_valid", valid_a, 0);
                check("midrst_cts", cts_a, 0);
                check("midrst_data", data_a, 0);
                exp_a.delete();
            end
        join

        // Line low through reset and afterwards must not start a frame.
        rx_a = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(200);
        rx_a = 1'b1;
        idle(20);
        check("lowrst_ferr", ferr_a, 0);
        check("lowrst_count", count_a, 0);
        send(0, 8'h6E, 0, 0, 1);
        ready_a = 1'b1;
        idle(5);
        check("lowrst_recv", exp_a.size(), 0);

        // Randomized traffic with a randomly stalling consumer.
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        any_bad = 1'b0;
        rand_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w = 8'($urandom_range(0, 255));
            send(0, w, 0, 0, 1);
            idle($urandom_range(0, 20));
        end
        for (int k = 0; k < 6; k++) begin
            bit bp;
            w = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 3) == 0);
            any_bad |= bp;
            send(1, w, bp, 0, 1);
            idle($urandom_range(0, 20));
        end
        rand_rdy = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1;
        idle(20);
        check("rand_a_drained", exp_a.size(), 0);
        check("rand_b_drained", exp_b.size(), 0);
        check("rand_ovf", {ovf_a, ovf_b}, 0);
        check("rand_ferr", {ferr_a, ferr_b}, 0);
        check("rand_perr_b", perr_b, any_bad);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
